memory_game_round_ctrl: RTL and testbench

Game sequencer for the memory game. It generates a pseudo-random digit sequence for the current stage and plays it out on the LEDs at game-tick pace. While playing, it writes each digit into the number memory through the we/wn/d interface. It then scores the player's switch entries and accumulates correct/incorrect totals across stages. It sits between the key edge detectors, the game clock generator, the number memory and the score display controller, and replaces ad-hoc start/countdown sequencing.

---
 rtl/memory_game_pkg.sv | 26 ++
 rtl/lfsr_digit_gen.sv | 21 ++
 rtl/memory_game_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_memory_game_round_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and helpers for the memory game sequencer.
package memory_game_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_INPUT = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam int         SCORE_MAX = 99;
  localparam int         DIGITS    = 10;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Out-of-range digits map to all-zero.
  function automatic logic [DIGITS-1:0] digit_onehot(input logic [3:0] dg);
    logic [DIGITS-1:0] one;
    one = DIGITS'(1);
    return one << dg;
  endfunction

  function automatic logic [6:0] sat_inc(input logic [6:0] c);
    return (c >= 7'(SCORE_MAX)) ? c : c + 7'd1;
  endfunction
endpackage

// File: rtl/lfsr_digit_gen.sv
// Free-running 8-bit Galois LFSR folded to a decimal digit 0..9.
module lfsr_digit_gen #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] digit
);
  import memory_game_pkg::*;

  logic [7:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign digit = (lfsr_q[3:0] >= 4'd10) ? lfsr_q[3:0] - 4'd10 : lfsr_q[3:0];
endmodule

// File: rtl/memory_game_round_ctrl.sv
// Memory game round sequencer: generate, play out, score, and advance stages.
module memory_game_round_ctrl #(
  parameter int         START_LEN  = 3,
  parameter int         MAX_LEN    = 10,
  parameter int         SHOW_TICKS = 2,
  parameter int         GAP_TICKS  = 1,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick,
  input  logic       start_p,
  input  logic       enter_p,
  input  logic       next_p,
  input  logic [9:0] sw,
  output logic [9:0] led,
  output logic       we,
  output logic [3:0] wn,
  output logic [9:0] d,
  output logic [2:0] phase,
  output logic [3:0] stage_len,
  output logic [6:0] correct,
  output logic [6:0] incorrect,
  output logic       busy
);
  import memory_game_pkg::*;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d, len_q, len_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [6:0]        cor_q, cor_d, inc_q, inc_d;
  logic [3:0]        seq_q [MAX_LEN];
  logic [3:0]        digit, seq_rd;
  logic [DIGITS-1:0] shown;
  logic              last;
  logic [9:0]        led_q, led_d, d_q, d_d;
  logic [3:0]        wn_q, wn_d;
  logic              we_q, we_d, busy_q, busy_d;

  lfsr_digit_gen #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(resetn), .digit(digit));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    tcnt_d  = tcnt_q;
    cor_d   = cor_q;
    inc_d   = inc_q;
    last    = (idx_q == len_q - 4'd1);
    if (start_p) begin
      state_d = ST_GEN;
      idx_d   = '0;
      len_d   = 4'(START_LEN);
      tcnt_d  = '0;
      cor_d   = '0;
      inc_d   = '0;
    end else begin
      case (state_q)
        ST_GEN: begin
          if (last) begin
            idx_d   = '0;
            tcnt_d  = '0;
            state_d = ST_SHOW;
          end else idx_d = idx_q + 4'd1;
        end
        ST_SHOW: if (tick) begin
          if (tcnt_q == 8'(SHOW_TICKS - 1)) begin
            tcnt_d  = '0;
            state_d = ST_GAP;
          end else tcnt_d = tcnt_q + 8'd1;
        end
        ST_GAP: if (tick) begin
          if (tcnt_q == 8'(GAP_TICKS - 1)) begin
            tcnt_d = '0;
            if (last) begin
              idx_d   = '0;
              state_d = ST_INPUT;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_SHOW;
            end
          end else tcnt_d = tcnt_q + 8'd1;
        end
        ST_INPUT: if (enter_p) begin
          if (sw == digit_onehot(seq_q[idx_q])) cor_d = sat_inc(cor_q);
          else                                  inc_d = sat_inc(inc_q);
          if (last) begin
            idx_d   = '0;
            state_d = ST_DONE;
          end else idx_d = idx_q + 4'd1;
        end
        ST_DONE: if (next_p) begin
          len_d   = (len_q < 4'(MAX_LEN)) ? len_q + 4'd1 : len_q;
          idx_d   = '0;
          state_d = ST_GEN;
        end
        default: ;
      endcase
    end
  end

  // A one-digit stage enters SHOW on the same edge seq[0] is written; forward it.
  always_comb begin
    seq_rd = (state_q == ST_GEN && idx_d == idx_q) ? digit : seq_q[idx_d];
    shown  = digit_onehot(seq_rd);
    we_d   = (state_d == ST_SHOW);
    d_d    = we_d ? shown : '0;
    led_d  = we_d ? shown : ((state_d == ST_INPUT) ? sw : '0);
    wn_d   = we_d ? idx_d : wn_q;
    busy_d = (state_d == ST_GEN) || (state_d == ST_SHOW) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk) begin
    if (!resetn && !start_p && state_q == ST_GEN) seq_q[idx_q] <= digit;
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= 4'(START_LEN);
      tcnt_q  <= '0;
      cor_q   <= '0;
      inc_q   <= '0;
      led_q   <= '0;
      we_q    <= 1'b0;
      wn_q    <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      tcnt_q  <= tcnt_d;
      cor_q   <= cor_d;
      inc_q   <= inc_d;
      led_q   <= led_d;
      we_q    <= we_d;
      wn_q    <= wn_d;
      d_q     <= d_d;
      busy_q  <= busy_d;
    end
  end

  assign phase     = state_q;
  assign stage_len = len_q;
  assign correct   = cor_q;
  assign incorrect = inc_q;
  assign led       = led_q;
  assign we        = we_q;
  assign wn        = wn_q;
  assign d         = d_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_memory_game_round_ctrl.sv
// Scoreboard bench: stimulus queues expected memory writes, a monitor checks them.
module tb_memory_game_round_ctrl;
  logic       clk = 1'b0;
  logic       resetn, tick, start_p, enter_p, next_p;
  logic [9:0] sw, led, d;
  logic       we, busy;
  logic [3:0] wn, stage_len;
  logic [2:0] phase;
  logic [6:0] correct, incorrect;

  always #5 clk = ~clk;

  memory_game_round_ctrl dut (
    .clk(clk), .resetn(resetn), .tick(tick), .start_p(start_p), .enter_p(enter_p),
    .next_p(next_p), .sw(sw), .led(led), .we(we), .wn(wn), .d(d), .phase(phase),
    .stage_len(stage_len), .correct(correct), .incorrect(incorrect), .busy(busy)
  );

  typedef struct { logic [3:0] wn; logic [9:0] d; } wr_t;
  wr_t        exp_q[$];
  int         checks = 0, errors = 0;
  int         exp_cor, exp_inc, exp_len;
  logic [7:0] m_lfsr;
  logic [3:0] exp_seq [10];
  bit         abort_pending = 0;
  logic       we_prev = 1'b0;
  int         run = 0;

  function automatic logic [3:0] fold(input logic [7:0] l);
    return (l[3:0] >= 4'd10) ? l[3:0] - 4'd10 : l[3:0];
  endfunction

  function automatic logic [9:0] oh(input logic [3:0] g);
    logic [9:0] one;
    one = 10'd1;
    return one << g;
  endfunction

  function automatic int sat(input int c);
    return (c >= 99) ? 99 : c + 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Golden LFSR, stepped on the same edges as the design.
  always @(posedge clk)
    m_lfsr <= resetn ? 8'hA5 : ({1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00));

  always @(negedge clk) begin
    wr_t e;
    if (we && !we_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual wn=%0d d=%b expected none", wn, d);
      end else begin
        e = exp_q.pop_front();
        chk("wr_wn", int'(wn), int'(e.wn));
        chk("wr_d", int'(d), int'(e.d));
        chk("wr_led", int'(led), int'(e.d));
      end
    end
    if (we) run++;
    else if (we_prev) begin
      if (abort_pending) abort_pending = 0;
      else chk("show_len", run, 8);
      run = 0;
    end
    we_prev = we;
  end

  // Cycle n=0 is the first cycle after the start/next edge; tick lands on
  // the 4th cycle of every SHOW so each SHOW is 8 clks and each GAP 4 clks.
  task automatic run_round(input int len, input int stop_n);
    for (int n = 0; n < 13 * len; n++) begin
      if (n == stop_n) begin
        tick = 1'b0;
        return;
      end
      tick = (n >= len) && ((n - len) % 4 == 3);
      if (n < len) begin
        exp_seq[n] = fold(m_lfsr);
        exp_q.push_back('{wn: 4'(n), d: oh(fold(m_lfsr))});
      end
      if (n == len - 1) chk("gen_phase", int'(phase), 1);
      if (n == len)     chk("gen_len_show", int'(phase), 2);
      @(posedge clk); #1;
    end
    tick = 1'b0;
    chk("input_phase", int'(phase), 4);
    chk("input_busy", int'(busy), 0);
  endtask

  task automatic do_start();
    start_p = 1'b1; @(posedge clk); #1; start_p = 1'b0;
    exp_cor = 0; exp_inc = 0; exp_len = 3;
  endtask

  task automatic do_next();
    next_p = 1'b1; @(posedge clk); #1; next_p = 1'b0;
  endtask

  task automatic enter(input logic [9:0] v, input bit good);
    sw = v; enter_p = 1'b1; @(posedge clk); #1; enter_p = 1'b0;
    if (good) exp_cor = sat(exp_cor);
    else      exp_inc = sat(exp_inc);
  endtask

  initial begin
    int g;
    resetn = 1'b1; tick = 1'b0; start_p = 1'b0; enter_p = 1'b0; next_p = 1'b0; sw = '0;
    exp_cor = 0; exp_inc = 0; exp_len = 3;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    chk("rst_phase", int'(phase), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_wn", int'(wn), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_stage_len", int'(stage_len), 3);
    chk("rst_correct", int'(correct), 0);
    chk("rst_incorrect", int'(incorrect), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lfsr", int'(dut.u_lfsr.lfsr_q), 8'hA5);

    do_next();
    chk("idle_ignores_next", int'(phase), 0);

    // Play-out timing and write sequence
    do_start();
    chk("start_busy", int'(busy), 1);
    run_round(3, -1);
    chk("queue_drained_1", exp_q.size(), 0);

    // Scoring
    do_next();
    chk("input_ignores_next", int'(phase), 4);
    enter(oh(exp_seq[0]), 1'b1);
    chk("led_echo", int'(led), int'(oh(exp_seq[0])));
    enter(10'b0000000011, 1'b0);
    enter(10'b0, 1'b0);
    chk("score_phase", int'(phase), 5);
    chk("score_correct", int'(correct), 1);
    chk("score_incorrect", int'(incorrect), 2);
    chk("done_led", int'(led), 0);
    sw = oh(exp_seq[0]); enter_p = 1'b1; @(posedge clk); #1; enter_p = 1'b0;
    chk("done_ignores_enter", int'(correct), exp_cor);

    // Stage advance up to and past MAX_LEN
    for (int k = 0; k < 8; k++) begin
      exp_len = (exp_len < 10) ? exp_len + 1 : 10;
      do_next();
      chk("stage_len", int'(stage_len), exp_len);
      run_round(exp_len, -1);
      for (int i = 0; i < exp_len; i++) enter(oh(exp_seq[i]), 1'b1);
      chk("stage_done", int'(phase), 5);
      chk("stage_correct", int'(correct), exp_cor);
    end

    // Saturation: correct reaches 99 and holds, incorrect keeps counting
    for (int r = 0; r < 5; r++) begin
      do_next();
      chk("sat_stage_len", int'(stage_len), 10);
      run_round(10, -1);
      for (int i = 0; i < 10; i++) begin
        if (r == 4 && i == 9) begin
          g = (int'(exp_seq[i]) + 1) % 10;
          enter(oh(4'(g)), 1'b0);
        end else enter(oh(exp_seq[i]), 1'b1);
      end
    end
    chk("sat_model", exp_cor, 99);
    chk("sat_correct", int'(correct), exp_cor);
    chk("sat_incorrect", int'(incorrect), exp_inc);

    // Restart while showing idx 1
    do_next();
    run_round(10, 23);
    chk("mid_show_we", int'(we), 1);
    chk("mid_show_wn", int'(wn), 1);
    abort_pending = 1;
    do_start();
    exp_q.delete();
    chk("restart_we", int'(we), 0);
    chk("restart_phase", int'(phase), 1);
    chk("restart_len", int'(stage_len), 3);
    chk("restart_correct", int'(correct), 0);
    chk("restart_incorrect", int'(incorrect), 0);
    run_round(3, -1);
    chk("queue_drained_2", exp_q.size(), 0);

    // start_p beats enter_p in the same cycle
    sw = oh(exp_seq[0]); enter_p = 1'b1; start_p = 1'b1;
    @(posedge clk); #1;
    enter_p = 1'b0; start_p = 1'b0;
    chk("prio_correct", int'(correct), 0);
    chk("prio_incorrect", int'(incorrect), 0);
    chk("prio_phase", int'(phase), 1);
    chk("prio_len", int'(stage_len), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
